// File: rtl/line_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : line_buffer_pkg
//  Purpose  : Shared image-pipeline definitions. These are the pixel width
//             and the fill-state enumeration used by the line buffer.
//  Revision : 1.0  initial release
// ============================================================================
package line_buffer_pkg;

  // Width of one raster pixel.
  localparam int PIX_W = 8;

  // Fill progress of the two line memories within a frame.
  typedef enum logic [1:0] {
    FILL0  = 2'd0,   // row 0 arriving, neither memory holds frame data
    FILL1  = 2'd1,   // row 1 arriving, only one prior row available
    STREAM = 2'd2    // two prior rows available, columns are valid
  } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/line_buffer_mem.sv
`default_nettype none
// ============================================================================
//  Module   : line_mem
//  Purpose  : IMG_W x 8 line memory. It has one write port and one
//             synchronous read port. A same-address read and write on one
//             edge returns the old data (read-before-write).
//  Revision : 1.0  initial release
// ============================================================================
module line_mem
  import line_buffer_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = PIX_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // The write and the registered read share one edge. Because both use
  // non-blocking assignments, a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : line_buffer
//  Purpose  : Two-line buffer. It turns a raster pixel stream into vertically
//             aligned 3-pixel columns (rows n-2, n-1, n) that feed a 3x3
//             window stage. A fill FSM masks columns until two full rows are
//             stored.
//  Revision : 1.0  initial release
// ============================================================================
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] r0,
  output logic [PIX_W-1:0] r1,
  output logic [PIX_W-1:0] r2,
  output logic             out_valid,
  output logic [CW-1:0]    out_col,
  output logic             out_eol
);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  logic [CW-1:0]    col;        // column of the next accepted pixel
  logic [CW-1:0]    col_next;
  logic [CW-1:0]    wr_col;     // effective column of the pixel on this cycle
  fill_state_t      state;
  fill_state_t      state_next;
  fill_state_t      pix_state;  // effective fill state of the pixel on this cycle
  logic [PIX_W-1:0] a0;         // LM0[col], i.e. row n-2
  logic [PIX_W-1:0] a1;         // LM1[col], i.e. row n-1

  // Work out the column and fill state of this pixel (sof forces col 0 and
  // FILL0), then step the column counter and the fill FSM.
  always_comb begin
    wr_col     = col;
    pix_state  = state;
    col_next   = col;
    state_next = state;
    if (pix_valid) begin
      if (sof) begin
        wr_col    = '0;
        pix_state = FILL0;
      end
      col_next   = (wr_col == LAST_COL) ? '0 : wr_col + CW'(1);
      state_next = pix_state;
      if (wr_col == LAST_COL) begin
        case (pix_state)
          FILL0:   state_next = FILL1;
          FILL1:   state_next = STREAM;
          default: state_next = pix_state;
        endcase
      end
    end
  end

  // Column counter and fill-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      state <= FILL0;
    end else begin
      col   <= col_next;
      state <= state_next;
    end
  end

  // Output column register. It updates only on accepted pixels, so it holds
  // across gaps. out_valid marks pixels that were accepted in STREAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0        <= '0;
      r1        <= '0;
      r2        <= '0;
      out_valid <= 1'b0;
      out_col   <= '0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= pix_valid && (pix_state == STREAM);
      if (pix_valid) begin
        r0      <= a0;
        r1      <= a1;
        r2      <= pix_in;
        out_col <= wr_col;
        out_eol <= (wr_col == LAST_COL);
      end
    end
  end

  // Both memories are read at col_next. This keeps the words for the next
  // pixel's column ready in the read registers before that pixel arrives,
  // so one edge can read, shift LM1->LM0, write the new pixel and register
  // the column. The read address never equals this edge's write address.
  // After a mid-row sof, the prefetched word belongs to the old column.
  // That word only reaches row-0 data, which the fill states mask.
  line_mem #(
    .DEPTH (IMG_W),
    .AW    (CW),
    .DW    (PIX_W)
  ) u_lm0 (
    .clk   (clk),
    .we    (pix_valid),
    .waddr (wr_col),
    .wdata (a1),
    .raddr (col_next),
    .rdata (a0)
  );

  line_mem #(
    .DEPTH (IMG_W),
    .AW    (CW),
    .DW    (PIX_W)
  ) u_lm1 (
    .clk   (clk),
    .we    (pix_valid),
    .waddr (wr_col),
    .wdata (pix_in),
    .raddr (col_next),
    .rdata (a1)
  );

endmodule
`default_nettype wire

// File: tb/tb_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_buffer
//  Purpose  : Self-checking bench for line_buffer with IMG_W=4. The reference
//             model keeps the pixels of the current frame in a queue. The
//             pixel with frame index k is valid once k >= 2*W, and its column
//             is {frame[k-2W], frame[k-W], frame[k]} at column k % W.
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_buffer;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [7:0]    pix_in    = '0;
  logic          pix_valid = 1'b0;
  logic          sof       = 1'b0;
  logic [7:0]    r0, r1, r2;
  logic          out_valid;
  logic [CW-1:0] out_col;
  logic          out_eol;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] frame_q [$];
  logic       exp_valid = 1'b0;
  logic       exp_known = 1'b1;   // r0/r1 are defined (reset or valid column)
  logic [7:0] exp_r0    = '0;
  logic [7:0] exp_r1    = '0;
  logic [7:0] exp_r2    = '0;
  int         exp_col   = 0;
  logic       exp_eol   = 1'b0;

  line_buffer #(
    .IMG_W (W),
    .CW    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .sof       (sof),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .out_valid (out_valid),
    .out_col   (out_col),
    .out_eol   (out_eol)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("r2",        32'(r2),        32'(exp_r2));
    chk("out_col",   32'(out_col),   32'(exp_col));
    chk("out_eol",   32'(out_eol),   32'(exp_eol));
    if (exp_known) begin
      chk("r0", 32'(r0), 32'(exp_r0));
      chk("r1", 32'(r1), 32'(exp_r1));
    end
  endtask

  // One clock cycle: drive at a falling edge, update the model, and check
  // at the next falling edge.
  task automatic step(input bit v, input logic [7:0] d, input bit s);
    int k;
    pix_valid = v;
    pix_in    = d;
    sof       = s;
    if (v) begin
      if (s) frame_q.delete();
      k = frame_q.size();
      frame_q.push_back(d);
      exp_valid = (k >= 2 * W);
      if (exp_valid) begin
        exp_r0    = frame_q[k - 2 * W];
        exp_r1    = frame_q[k - W];
        exp_known = 1'b1;
      end else begin
        exp_known = 1'b0;
      end
      exp_r2  = d;
      exp_col = k % W;
      exp_eol = ((k % W) == W - 1);
    end else begin
      exp_valid = 1'b0;
    end
    @(negedge clk);
    check_model();
  endtask

  // Asynchronous reset for two cycles. The outputs must clear at once,
  // without waiting for a clock edge.
  task automatic do_reset();
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    #1;
    frame_q.delete();
    exp_valid = 1'b0;
    exp_known = 1'b1;
    exp_r0    = '0;
    exp_r1    = '0;
    exp_r2    = '0;
    exp_col   = 0;
    exp_eol   = 1'b0;
    check_model();
    @(negedge clk);
    @(negedge clk);
    check_model();
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    @(negedge clk);
    do_reset();

    // Basic fill, then wrap and continuation: pixels 1..20, sof on pixel 1.
    for (int p = 1; p <= 20; p++) begin
      step(1'b1, 8'(p), p == 1);
      if (p <= 8) chk("fill_masked", 32'(out_valid), 32'd0);
      if (p == 9) begin
        chk("p9_r0", 32'(r0), 32'd1);
        chk("p9_r1", 32'(r1), 32'd5);
        chk("p9_r2", 32'(r2), 32'd9);
        chk("p9_col", 32'(out_col), 32'd0);
      end
      if (p == 16) begin
        chk("p16_r0", 32'(r0), 32'd8);
        chk("p16_r1", 32'(r1), 32'd12);
        chk("p16_r2", 32'(r2), 32'd16);
        chk("p16_eol", 32'(out_eol), 32'd1);
      end
      if (p >= 17) begin
        chk("wrap_r0", 32'(r0), 32'(p - 8));
        chk("wrap_r1", 32'(r1), 32'(p - 4));
        chk("wrap_col", 32'(out_col), 32'(p - 17));
      end
    end
    step(1'b0, 8'd0, 1'b0);

    // Same data with pix_valid toggled every other cycle.
    for (int p = 1; p <= 16; p++) begin
      step(1'b1, 8'(p), p == 1);
      if (p >= 9) begin
        chk("gap_r0", 32'(r0), 32'(p - 8));
        chk("gap_r1", 32'(r1), 32'(p - 4));
        chk("gap_valid_on", 32'(out_valid), 32'd1);
      end
      step(1'b0, 8'd0, 1'b0);
      chk("gap_idle_valid", 32'(out_valid), 32'd0);
      chk("gap_hold_r2", 32'(r2), 32'(p));
    end

    // sof on pixel 6 of a frame restarts the fill mid-row.
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 8'(100 + i), (i == 1) || (i == 6));
      if (i >= 6 && i <= 13) chk("sof_mid_masked", 32'(out_valid), 32'd0);
      if (i == 14) begin
        chk("sof_mid_valid", 32'(out_valid), 32'd1);
        chk("sof_mid_col0", 32'(out_col), 32'd0);
      end
    end
    step(1'b0, 8'd0, 1'b0);

    // Reset after 6 pixels, then restart without sof.
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(50 + i), i == 1);
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 8'(200 + i), 1'b0);
      chk("rst_restart_valid", 32'(out_valid), 32'(i >= 9));
    end

    // Random data, gaps, stray sof (qualified or not) and occasional resets.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        do_reset();
      end else if (r < 30) begin
        step(1'b0, 8'($urandom), 1'($urandom));
      end else begin
        step(1'b1, 8'($urandom), $urandom_range(0, 39) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_buffer.md
LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 The block SHALL have parameter IMG_W, default 64, meaning pixels per image row; legal range is 4..1024.
REQ-002 The block SHALL have parameter CW, default $clog2(IMG_W), meaning the column counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, with all logic on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port pix_in, input, 8 bits: raster-order pixel data.
REQ-006 The block SHALL have port pix_valid, input, 1 bit: pix_in is accepted on this cycle.
REQ-007 The block SHALL have port sof, input, 1 bit: start of frame, qualified by pix_valid; it marks the pixel at row 0, column 0.
REQ-008 The block SHALL have ports r0, r1, r2, output, 8 bits each: a vertically aligned column, where r0 is the oldest row (n-2), r1 is row n-1 and r2 is the current row n.
REQ-009 The block SHALL have port out_valid, output, 1 bit: r0..r2 form a valid column this cycle; it drives the downstream 3x3 window stage's in_valid.
REQ-010 The block SHALL have port out_col, output, CW bits: the column index of the current r0..r2 column.
REQ-011 The block SHALL have port out_eol, output, 1 bit: the current column is IMG_W-1.

Function
REQ-012 The block SHALL hold two line memories, LM0 and LM1, each IMG_W x 8 bits, addressed by column counter col.
REQ-013 On each accepted pixel, the block SHALL perform all of the following in the same edge:
- read a0 = LM0[col] and a1 = LM1[col];
- write LM0[col] <= a1 and LM1[col] <= pix_in;
- register r0 <= a0, r1 <= a1, r2 <= pix_in.
REQ-014 A same-address read and write in one cycle SHALL return the old data (read-before-write).
REQ-015 Latency from accepted pixel to the r0..r2 update SHALL be exactly 1 cycle.
REQ-016 col SHALL increment on each accepted pixel and wrap from IMG_W-1 to 0.
REQ-017 The fill state machine SHALL have states FILL0, FILL1 and STREAM, with reset state FILL0.
REQ-018 Fill transitions SHALL be FILL0->FILL1 and FILL1->STREAM on an accepted pixel at col==IMG_W-1; STREAM SHALL persist until sof or reset.
REQ-019 out_valid SHALL be 1 on the cycle after an accepted pixel whose state was STREAM, and 0 otherwise, including all cycles where pix_valid was 0.
REQ-020 The registered r0..r2, out_col and out_eol SHALL hold their values when pix_valid=0.
REQ-021 out_col SHALL equal the col of the pixel that produced the current column, and out_eol SHALL equal (that col == IMG_W-1).
REQ-022 When sof=1 with pix_valid=1, the pixel SHALL be treated as col 0 in FILL0, regardless of the current col or state.
REQ-023 Under REQ-022, that pixel's own output SHALL be invalid (out_valid=0), and col SHALL become 1 after the pixel.
REQ-024 sof with pix_valid=0 SHALL be ignored.
REQ-025 LM contents SHALL NOT be cleared by sof; stale data is masked by the fill states.
REQ-026 The block SHALL have no backpressure: every pix_valid pixel is accepted.

Reset
REQ-027 While rst_n=0, the outputs SHALL be r0=r1=r2=0, out_valid=0, out_col=0 and out_eol=0.
REQ-028 While rst_n=0, the internal state SHALL be col=0 and state FILL0.
REQ-029 LM contents SHALL be don't-care after reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame; the first pixel after release SHALL be treated as row 0, col 0, whether or not sof is present.
REQ-031 Reset deassertion SHALL take effect on the first clk edge at which rst_n=1, with no pixel lost at that edge.

Structure
REQ-032 The pixel width constant (8) and the fill-state enumeration (FILL0/FILL1/STREAM) SHALL be defined in the shared image-pipeline package.
REQ-033 Each line memory SHALL be an instance of sub-module line_mem (IMG_W x 8, one synchronous read port and one write port, read-before-write), instantiated twice.
REQ-034 The counter, FSM and output registers SHALL reside in the line_buffer top.

Verification
REQ-035 The bench SHALL cover reset mid-frame: with IMG_W=4, assert rst_n=0 after 6 pixels -> outputs 0; restart with 12 pixels -> first out_valid after pixel 9.
REQ-036 The bench SHALL cover basic fill: with IMG_W=4, stream pixels 1..16 continuously starting with sof -> out_valid=0 for the outputs of pixels 1..8.
REQ-037 Continuing REQ-036, the pixel-9 output SHALL be r0=1, r1=5, r2=9, out_col=0, and the pixel-16 output SHALL be r0=8, r1=12, r2=16, out_eol=1.
REQ-038 The bench SHALL cover gaps: stream the same data as REQ-036 with pix_valid toggled every other cycle -> identical r0..r2 sequence on out_valid cycles, and out_valid=0 on idle cycles with outputs held.
REQ-039 The bench SHALL cover wrap and continuation: with IMG_W=4, feed 20 pixels -> pixels 17..20 give r0=9..12, r1=13..16, r2=17..20, with out_col 0..3.
REQ-040 The bench SHALL cover sof mid-row: assert sof on pixel 6 of a frame -> out_valid stays 0 for that pixel and the 7 following; the pixel 8 positions later gives out_col=0.
REQ-041 The bench SHALL cover same-address read/write: back-to-back pixels with no gaps across a row wrap -> r0/r1 reflect the pre-write LM data, with no forwarding of same-cycle writes.
